// File: rtl/ahb_matrix_pkg.sv
// Shared AHB encodings and burst helpers for the bus-matrix output stage.
package ahb_matrix_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Number of SEQ beats that follow the NONSEQ of a fixed-length burst.
    function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
        logic [3:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Counts remaining SEQ beats of the granted port's fixed-length burst.
module ahb_burst_tracker
    import ahb_matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic       active,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    output logic [3:0] rem_next
);

    logic [3:0] beat_cnt;

    always_comb begin
        rem_next = 4'd0;
        if (active) begin
            case (htrans)
                HTRANS_NONSEQ: rem_next = burst_beats_m1(hburst);
                HTRANS_SEQ:    rem_next = (beat_cnt != 4'd0) ? beat_cnt - 4'd1 : 4'd0;
                HTRANS_BUSY:   rem_next = beat_cnt;
                default:       rem_next = 4'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= 4'd0;
        end else if (advance) begin
            beat_cnt <= rem_next;
        end
    end

endmodule

// File: rtl/ahb_rr_output_arbiter.sv
// Round-robin slave-port arbiter; holds the grant across locked sequences and
// fixed-length bursts so neither is ever split between masters.
module ahb_rr_output_arbiter
    import ahb_matrix_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned PORT_W    = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANTED = 1'b1;

    logic [0:0]        state;
    logic [PORT_W-1:0] last_port;
    logic [PORT_W-1:0] winner;
    logic              found;
    logic              hold;
    logic [3:0]        rem_next;
    int unsigned       idx;

    assign no_port = (state == ST_IDLE);

    ahb_burst_tracker u_tracker (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .advance  (HREADYM),
        .active   (HSELM & ~no_port),
        .htrans   (HTRANSM),
        .hburst   (HBURSTM),
        .rem_next (rem_next)
    );

    assign hold = ~no_port & (HMASTLOCKM | (rem_next != 4'd0));

    // Scan from last_port+1 around to last_port itself; the last grantee comes last.
    always_comb begin
        winner = last_port;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = 32'(last_port) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && req_port[idx[PORT_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PORT_W-1:0];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= ST_IDLE;
            addr_in_port <= '0;
            last_port    <= PORT_W'(NUM_PORTS - 1);
        end else if (HREADYM) begin
            if (hold) begin
                state <= ST_GRANTED;
            end else if (found) begin
                state        <= ST_GRANTED;
                addr_in_port <= winner;
                last_port    <= winner;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ahb_rr_output_arbiter.sv
// Directed self-checking bench for the round-robin output-stage arbiter.
module tb_ahb_rr_output_arbiter;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned PORT_W    = 2;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000, B_INCR4 = 3'b011, B_INCR8 = 3'b101;

    logic                 HCLK = 1'b0;
    logic                 HRESETn = 1'b0;
    logic [NUM_PORTS-1:0] req_port = '0;
    logic                 HREADYM = 1'b1;
    logic                 HSELM = 1'b0;
    logic [1:0]           HTRANSM = T_IDLE;
    logic [2:0]           HBURSTM = B_SINGLE;
    logic                 HMASTLOCKM = 1'b0;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 HCLK = ~HCLK;

    ahb_rr_output_arbiter #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port)
    );

    // Advance one clock edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [2:0] req, input logic sel, input logic [1:0] tr,
                         input logic [2:0] bu, input logic lock);
        req_port   = req;
        HSELM      = sel;
        HTRANSM    = tr;
        HBURSTM    = bu;
        HMASTLOCKM = lock;
    endtask

    // Reset, then one edge with only req_mask requesting and HSELM low.
    task automatic reset_and_grant(input logic [2:0] req_mask);
        HRESETn = 1'b0;
        HREADYM = 1'b1;
        drive(req_mask, 1'b0, T_IDLE, B_SINGLE, 1'b0);
        tick();
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        HREADYM = 1'b1;
        drive(3'b111, 1'b0, T_IDLE, B_SINGLE, 1'b0);
        tick();
        tick();
        n_tests++;
        if (no_port !== 1'b1 || addr_in_port !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold no_port=%b addr=%0d exp no_port=1 addr=0", no_port,
                     addr_in_port);
        end
        HRESETn = 1'b1;
        tick();
        n_tests++;
        if (no_port !== 1'b0 || addr_in_port !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant no_port=%b addr=%0d exp no_port=0 addr=0",
                     no_port, addr_in_port);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_seq [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
        reset_and_grant(3'b111);
        drive(3'b111, 1'b1, T_NSEQ, B_SINGLE, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (no_port !== 1'b0 || addr_in_port !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL rr_step%0d no_port=%b addr=%0d exp no_port=0 addr=%0d", i,
                         no_port, addr_in_port, exp_seq[i]);
            end
        end
        drive(3'b000, 1'b1, T_NSEQ, B_SINGLE, 1'b0);
        tick();
        n_tests++;
        if (no_port !== 1'b1 || addr_in_port !== 2'd1) begin
            n_fail++;
            $display("FAIL rr_no_req no_port=%b addr=%0d exp no_port=1 addr=1", no_port,
                     addr_in_port);
        end
        // Sole requester is re-granted on consecutive arbitration points.
        drive(3'b001, 1'b0, T_IDLE, B_SINGLE, 1'b0);
        tick();
        drive(3'b001, 1'b1, T_NSEQ, B_SINGLE, 1'b0);
        tick();
        n_tests++;
        if (no_port !== 1'b0 || addr_in_port !== 2'd0) begin
            n_fail++;
            $display("FAIL rr_sole_regrant no_port=%b addr=%0d exp no_port=0 addr=0", no_port,
                     addr_in_port);
        end
    endtask

    task automatic test_burst_hold();
        logic [1:0] tr_seq [5] = '{T_NSEQ, T_SEQ, T_BUSY, T_SEQ, T_SEQ};
        logic [1:0] exp_seq [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        reset_and_grant(3'b111);
        drive(3'b111, 1'b0, T_IDLE, B_SINGLE, 1'b0);
        tick();
        n_tests++;
        if (addr_in_port !== 2'd1) begin
            n_fail++;
            $display("FAIL burst_setup addr=%0d exp 1", addr_in_port);
        end
        for (int i = 0; i < 5; i++) begin
            drive(3'b111, 1'b1, tr_seq[i], B_INCR4, 1'b0);
            tick();
            n_tests++;
            if (no_port !== 1'b0 || addr_in_port !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL burst_beat%0d no_port=%b addr=%0d exp no_port=0 addr=%0d", i,
                         no_port, addr_in_port, exp_seq[i]);
            end
        end
    endtask

    task automatic test_lock();
        logic [1:0] tr_seq [4] = '{T_NSEQ, T_IDLE, T_NSEQ, T_IDLE};
        logic       lk_seq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] exp_seq [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
        reset_and_grant(3'b111);
        for (int i = 0; i < 4; i++) begin
            drive(3'b110, 1'b1, tr_seq[i], B_SINGLE, lk_seq[i]);
            tick();
            n_tests++;
            if (no_port !== 1'b0 || addr_in_port !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL lock_step%0d no_port=%b addr=%0d exp no_port=0 addr=%0d", i,
                         no_port, addr_in_port, exp_seq[i]);
            end
        end
    endtask

    task automatic test_wait_states();
        logic [2:0] stall_req [3] = '{3'b110, 3'b010, 3'b100};
        reset_and_grant(3'b001);
        drive(3'b111, 1'b1, T_NSEQ, B_INCR8, 1'b0);
        tick();
        drive(3'b111, 1'b1, T_SEQ, B_INCR8, 1'b0);
        tick();
        HREADYM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(stall_req[i], 1'b1, T_SEQ, B_INCR8, 1'b0);
            tick();
            n_tests++;
            if (no_port !== 1'b0 || addr_in_port !== 2'd0) begin
                n_fail++;
                $display("FAIL stall%0d no_port=%b addr=%0d exp no_port=0 addr=0", i, no_port,
                         addr_in_port);
            end
        end
        HREADYM = 1'b1;
        // Six SEQ beats remain; the grant may only move on the last of them.
        for (int i = 0; i < 6; i++) begin
            drive(3'b111, 1'b1, T_SEQ, B_INCR8, 1'b0);
            tick();
            n_tests++;
            if (addr_in_port !== ((i == 5) ? 2'd1 : 2'd0)) begin
                n_fail++;
                $display("FAIL resume_beat%0d addr=%0d exp %0d", i, addr_in_port,
                         (i == 5) ? 1 : 0);
            end
        end
    endtask

    task automatic test_early_term_and_async_reset();
        reset_and_grant(3'b100);
        n_tests++;
        if (addr_in_port !== 2'd2) begin
            n_fail++;
            $display("FAIL term_setup addr=%0d exp 2", addr_in_port);
        end
        drive(3'b111, 1'b1, T_NSEQ, B_INCR8, 1'b0);
        tick();
        drive(3'b111, 1'b1, T_SEQ, B_INCR8, 1'b0);
        tick();
        drive(3'b111, 1'b1, T_IDLE, B_INCR8, 1'b0);
        tick();
        n_tests++;
        if (no_port !== 1'b0 || addr_in_port !== 2'd0) begin
            n_fail++;
            $display("FAIL term_rearb no_port=%b addr=%0d exp no_port=0 addr=0", no_port,
                     addr_in_port);
        end
        // A cleared beat count means a stray SEQ does not extend the hold.
        drive(3'b111, 1'b1, T_SEQ, B_INCR8, 1'b0);
        tick();
        n_tests++;
        if (addr_in_port !== 2'd1) begin
            n_fail++;
            $display("FAIL term_cnt_cleared addr=%0d exp 1", addr_in_port);
        end
        drive(3'b111, 1'b1, T_NSEQ, B_INCR8, 1'b0);
        tick();
        #2;
        HRESETn = 1'b0;
        #1;
        n_tests++;
        if (no_port !== 1'b1 || addr_in_port !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset no_port=%b addr=%0d exp no_port=1 addr=0", no_port,
                     addr_in_port);
        end
        tick();
        HRESETn = 1'b1;
        drive(3'b111, 1'b0, T_IDLE, B_SINGLE, 1'b0);
        tick();
        n_tests++;
        if (no_port !== 1'b0 || addr_in_port !== 2'd0) begin
            n_fail++;
            $display("FAIL post_reset_grant no_port=%b addr=%0d exp no_port=0 addr=0",
                     no_port, addr_in_port);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_hold();
        test_lock();
        test_wait_states();
        test_early_term_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
